// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude/equality comparator: walks captured operands MSB-first,
// one 1-bit equality cell evaluation per clock, and reports eq/gt/lt with a done pulse.
module serial_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;

    // One bit of the walk is registered (pend_*) and judged on the following edge.
    logic pend_valid;
    logic pend_eq;
    logic pend_a;
    logic pend_b;
    logic pend_last;

    logic diff_seen;
    logic diff_gt;
    logic diff_lt;

    logic bit_a;
    logic bit_b;
    logic cell_eq;
    logic new_diff;
    logic finish;
    logic res_eq;
    logic res_gt;
    logic res_lt;

    function automatic logic bit_equal(input logic i1, input logic i2);
        return (i1 & i2) | (~i1 & ~i2);
    endfunction

    always_comb begin
        bit_a    = a_reg[idx];
        bit_b    = b_reg[idx];
        cell_eq  = bit_equal(bit_a, bit_b);
        new_diff = pend_valid && !pend_eq && !diff_seen;
        finish   = pend_valid && (pend_last || (EARLY_EXIT && new_diff));
        res_eq   = !diff_seen && !new_diff;
        res_gt   = diff_seen ? diff_gt : (new_diff && pend_a);
        res_lt   = diff_seen ? diff_lt : (new_diff && pend_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            idx        <= '0;
            pend_valid <= 1'b0;
            pend_eq    <= 1'b0;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            pend_last  <= 1'b0;
            diff_seen  <= 1'b0;
            diff_gt    <= 1'b0;
            diff_lt    <= 1'b0;
            eq         <= 1'b0;
            gt         <= 1'b0;
            lt         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        idx        <= IDX_W'(WIDTH - 1);
                        pend_valid <= 1'b0;
                        pend_last  <= 1'b0;
                        diff_seen  <= 1'b0;
                        diff_gt    <= 1'b0;
                        diff_lt    <= 1'b0;
                        eq         <= 1'b0;
                        gt         <= 1'b0;
                        lt         <= 1'b0;
                    end
                end
                SCAN: begin
                    if (finish) begin
                        eq         <= res_eq;
                        gt         <= res_gt;
                        lt         <= res_lt;
                        pend_valid <= 1'b0;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_eq    <= cell_eq;
                        pend_a     <= bit_a;
                        pend_b     <= bit_b;
                        pend_last  <= (idx == '0);
                        // idx==0 is terminal; holding it there avoids underflow
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                        end
                        if (new_diff) begin
                            diff_seen <= 1'b1;
                            diff_gt   <= pend_a;
                            diff_lt   <= pend_b;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized self-checking bench: one early-exit and one full-scan comparator share
// the same stimulus and are checked against an arithmetic reference model.
module tb_serial_comparator;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;

    logic busy1, done1, eq1, gt1, lt1;
    logic busy0, done0, eq0, gt0, lt0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) u_dut_early (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
    );

    serial_comparator #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // {eq,gt,lt} straight from unsigned arithmetic
    function automatic logic [2:0] model_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x == y) return 3'b100;
        else if (x > y) return 3'b010;
        else return 3'b001;
    endfunction

    // Edges from the accepting edge to the one that raises done: bits examined + 1
    function automatic int model_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit early);
        int n;
        n = WIDTH;
        if (early) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (x[i] != y[i]) begin
                    n = WIDTH - i;
                    break;
                end
            end
        end
        return n + 1;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input bit inject);
        int lat1;
        int lat0;
        int exp1;
        int exp0;
        logic [2:0] exp_res;
        exp_res = model_result(op_a, op_b);
        exp1 = model_latency(op_a, op_b, 1'b1);
        exp0 = model_latency(op_a, op_b, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = op_a;
        b = op_b;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        checkOutput("busy_after_accept", {busy1, busy0, eq1, gt1, lt1, eq0, gt0, lt0}, 8'b1100_0000);
        lat1 = -1;
        lat0 = -1;
        for (int cyc = 1; cyc <= 2 * WIDTH + 4 && (lat1 < 0 || lat0 < 0); cyc++) begin
            @(negedge clk);
            if (inject && cyc == 3) begin
                start = 1'b1;
                a = '0;
                b = '1;
            end else begin
                start = 1'b0;
            end
            if (done1 && lat1 < 0) lat1 = cyc;
            if (done0 && lat0 < 0) lat0 = cyc;
            checkOutput("invariant_early", {busy1 & done1, busy1 & (eq1 | gt1 | lt1)}, 2'b00);
            checkOutput("invariant_full", {busy0 & done0, busy0 & (eq0 | gt0 | lt0)}, 2'b00);
        end
        start = 1'b0;
        checkOutput($sformatf("latency_early %h/%h", op_a, op_b), lat1, exp1);
        checkOutput($sformatf("latency_full %h/%h", op_a, op_b), lat0, exp0);
        checkOutput($sformatf("result_early %h/%h", op_a, op_b), {eq1, gt1, lt1}, exp_res);
        checkOutput($sformatf("result_full %h/%h", op_a, op_b), {eq0, gt0, lt0}, exp_res);
        @(negedge clk);
        checkOutput("idle_after_done", {busy1, done1, busy0, done0}, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("result_hold", {eq1, gt1, lt1, eq0, gt0, lt0}, {exp_res, exp_res});
    endtask

    task automatic applyMidScanReset();
        @(negedge clk);
        start = 1'b1;
        a = 8'h3C;
        b = 8'h3D;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_reset", {busy1, busy0}, 2'b11);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {busy1, done1, eq1, gt1, lt1, busy0, done0, eq0, gt0, lt0}, 10'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_done_in_reset", {done1, done0, busy1, busy0}, 4'b0000);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bit inj;
        $display("[TB] serial_comparator bench start");
        #2;
        checkOutput("reset_state", {busy1, done1, eq1, gt1, lt1, busy0, done0, eq0, gt0, lt0}, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'hA5, 8'hA5, 1'b0);
        applyStimulus(8'h80, 8'h7F, 1'b0);
        applyStimulus(8'h12, 8'h13, 1'b0);
        applyStimulus(8'hC0, 8'h7F, 1'b0);
        applyStimulus(8'h12, 8'h13, 1'b1);
        applyStimulus(8'h00, 8'hFF, 1'b0);
        applyStimulus(8'h01, 8'h00, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        applyMidScanReset();
        applyStimulus(8'h55, 8'h55, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            inj = (model_latency(ra, rb, 1'b1) >= 4) && ($urandom_range(0, 1) == 1);
            applyStimulus(ra, rb, inj);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
